run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Companion to the 5-phase one-hot phase generator; consumes its `phase` vector and drives its `hlt` input.
- Halts at instruction boundaries, on a decoded HLT instruction or an external debug halt request.
- Checks every phase transition for protocol errors and enters a sticky fault state on any violation.
- Provides retired-instruction and running-cycle counters for debug and performance readout.

Parameters:
CNT_W, 32, width of inst_cnt and cyc_cnt

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
phase  in  5  one-hot phase from phase generator; bit0 F, bit1 R, bit2 X, bit3 M, bit4 W; all-zero = stopped
is_hlt  in  1  decoded HLT instruction; sampled only while phase[2] (X) is 1
halt_req  in  1  external debug halt request; level, sampled every cycle
hlt  out  1  to phase generator; 1 forces phase to 0 on next edge
running  out  1  1 while state is RUN
fault  out  1  sticky protocol-error flag
halt_cause  out  2  00 none, 01 HLT instruction, 10 external request, 11 fault
inst_cnt  out  CNT_W  instructions retired (W phases completed)
cyc_cnt  out  CNT_W  clock cycles spent in RUN

Behaviour:
- Reset, asynchronous on n_rst=0:
  - state=IDLE; pending=0; prev_phase=0; all counters 0.
  - halt_cause=00, fault=0, running=0, hlt=0.
- States: IDLE, RUN, HALTED, FAULT.
- IDLE:
  - phase==00000: stay in IDLE.
  - phase==00001: go to RUN.
  - Any other phase value: go to FAULT.
- RUN, evaluated each cycle:
  - Expected phase = prev_phase rotated left by one (W wraps to F).
  - phase != expected, or phase==00000: go to FAULT.
  - Exception: phase==00000 in the cycle after a halt-W cycle is legal; go to HALTED instead.
- Halt pending:
  - Set at the edge where (state==RUN or IDLE) and ((phase[2] and is_hlt) or halt_req).
  - Cause latched at the same edge: 01 if the HLT condition is true, else 10.
  - If both are true in the same cycle, HLT wins (cause 01). Only one halt results.
  - Once set, cause is not overwritten.
  - halt_req asserted in IDLE: the first instruction runs fully, then the block halts.
- hlt output is combinational from registered state plus phase: hlt = (pending and phase[4]) or state==HALTED or state==FAULT.
  - A halting instruction therefore completes its W phase.
  - The phase generator loads 00000 on the following edge.
- HALTED:
  - phase must remain 00000; any nonzero phase goes to FAULT.
  - Exit only by n_rst.
- FAULT:
  - fault=1 and halt_cause=11, overriding any earlier cause. hlt=1.
  - Exit only by n_rst.
- Counters:
  - inst_cnt increments on each cycle with phase==10000 in RUN, including the halting instruction.
  - cyc_cnt increments on each RUN cycle.
  - Both saturate at all-ones and never wrap.
  - Both freeze in HALTED and FAULT.
- prev_phase is registered every cycle from phase.
- running = (state==RUN).

Test Plan:
1. Reset, then phase rotates from 00001 with no halt for 3 full instructions (15 cycles) -> running=1, inst_cnt=3, cyc_cnt=15, hlt=0, fault=0.
2. is_hlt=1 during X of the 2nd instruction -> hlt=1 exactly during that instruction's W cycle; next phase=00000; state HALTED; halt_cause=01; inst_cnt=2; counters then frozen for 20 further cycles.
3. halt_req pulsed for one cycle during R of the 1st instruction -> halt at W of instruction 1; halt_cause=10; inst_cnt=1.
4. is_hlt and halt_req both 1 in the same X cycle -> halt_cause=01; a single hlt W cycle.
5. Phase jumps 00010 -> 01000 in RUN -> fault=1 next cycle; halt_cause=11; hlt=1; counters frozen. Assert n_rst -> all outputs 0.
6. CNT_W=4; run 20 instructions -> inst_cnt saturates at 15 and holds; cyc_cnt saturates at 15.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller for the 5-phase one-hot phase generator: halts at instruction
// boundaries, checks the phase sequence, and keeps retired-instruction/cycle counters.
module run_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [4:0]       phase,
  input  logic             is_hlt,
  input  logic             halt_req,
  output logic             hlt,
  output logic             running,
  output logic             fault,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;
  localparam logic [1:0] StFault  = 2'd3;

  localparam logic [4:0] PhNone = 5'b00000;
  localparam logic [4:0] PhF    = 5'b00001;
  localparam logic [4:0] PhW    = 5'b10000;

  localparam logic [1:0] CauseNone  = 2'b00;
  localparam logic [1:0] CauseHlt   = 2'b01;
  localparam logic [1:0] CauseReq   = 2'b10;
  localparam logic [1:0] CauseFault = 2'b11;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             pending_q, pending_d;
  logic [1:0]       cause_q, cause_d;
  logic [4:0]       prev_q;
  logic             halt_w_q, halt_w_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [4:0] phase_exp;
  logic       hlt_hit;
  logic       halt_cond;
  logic       in_run;

  assign phase_exp = {prev_q[3:0], prev_q[4]};
  assign hlt_hit   = phase[2] & is_hlt;
  assign halt_cond = hlt_hit | halt_req;
  assign in_run    = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (phase == PhF) begin
          state_d = StRun;
        end else if (phase != PhNone) begin
          state_d = StFault;
        end
      end
      StRun: begin
        // Stopping right after the halting W is the only legal way out of RUN.
        if (phase == PhNone && halt_w_q) begin
          state_d = StHalted;
        end else if (phase == PhNone || phase != phase_exp) begin
          state_d = StFault;
        end
      end
      StHalted: begin
        if (phase != PhNone) begin
          state_d = StFault;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    cause_d   = cause_q;
    if (!pending_q && (state_q == StIdle || in_run) && halt_cond) begin
      pending_d = 1'b1;
      cause_d   = hlt_hit ? CauseHlt : CauseReq;
    end
  end

  always_comb begin
    inst_d = inst_q;
    cyc_d  = cyc_q;
    if (in_run) begin
      if (cyc_q != CntMax) begin
        cyc_d = cyc_q + CntOne;
      end
      if (phase == PhW && inst_q != CntMax) begin
        inst_d = inst_q + CntOne;
      end
    end
  end

  assign halt_w_d = in_run && pending_q && (phase == PhW);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      cause_q   <= CauseNone;
      prev_q    <= PhNone;
      halt_w_q  <= 1'b0;
      inst_q    <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      prev_q    <= phase;
      halt_w_q  <= halt_w_d;
      inst_q    <= inst_d;
      cyc_q     <= cyc_d;
    end
  end

  assign hlt        = (pending_q && phase[4]) || (state_q == StHalted) || (state_q == StFault);
  assign running    = in_run;
  assign fault      = (state_q == StFault);
  assign halt_cause = (state_q == StFault) ? CauseFault : cause_q;
  assign inst_cnt   = inst_q;
  assign cyc_cnt    = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a phase-generator stand-in drives randomized and directed runs;
// outputs of a 32-bit and a 4-bit counter instance are compared against a reference model.
module tb_run_ctrl;

  logic        clk;
  logic        n_rst;
  logic [4:0]  phase;
  logic        is_hlt;
  logic        halt_req;

  logic        hlt, running, fault;
  logic [1:0]  halt_cause;
  logic [31:0] inst_cnt, cyc_cnt;

  logic        hlt4, running4, fault4;
  logic [1:0]  halt_cause4;
  logic [3:0]  inst_cnt4, cyc_cnt4;

  run_ctrl #(.CNT_W(32)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .phase      (phase),
    .is_hlt     (is_hlt),
    .halt_req   (halt_req),
    .hlt        (hlt),
    .running    (running),
    .fault      (fault),
    .halt_cause (halt_cause),
    .inst_cnt   (inst_cnt),
    .cyc_cnt    (cyc_cnt)
  );

  run_ctrl #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .n_rst      (n_rst),
    .phase      (phase),
    .is_hlt     (is_hlt),
    .halt_req   (halt_req),
    .hlt        (hlt4),
    .running    (running4),
    .fault      (fault4),
    .halt_cause (halt_cause4),
    .inst_cnt   (inst_cnt4),
    .cyc_cnt    (cyc_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode is a plain integer, counters are unbounded and clipped on compare.
  localparam int MIdle = 0, MRun = 1, MHalted = 2, MFault = 3;
  int          m_mode;
  bit          m_pending;
  int          m_cause;
  logic [4:0]  m_prev;
  bit          m_last_halt_w;
  int unsigned m_inst, m_cyc;

  function automatic logic [4:0] rot(input logic [4:0] p);
    return (p == 5'd16) ? 5'd1 : 5'(p * 2);
  endfunction

  function automatic int unsigned clip(input int unsigned v, input int unsigned maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic bit model_hlt();
    return (m_pending && phase[4]) || m_mode == MHalted || m_mode == MFault;
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_pending = 0; m_cause = 0; m_prev = '0;
    m_last_halt_w = 0; m_inst = 0; m_cyc = 0;
  endtask

  task automatic model_update();
    int  nxt;
    bit  hlt_now;
    bit  hit;
    hlt_now = model_hlt();
    hit     = phase[2] && is_hlt;
    nxt     = m_mode;
    if (m_mode == MIdle) begin
      if (phase == 5'd1) nxt = MRun;
      else if (phase != 5'd0) nxt = MFault;
    end else if (m_mode == MRun) begin
      if (phase == 5'd0 && m_last_halt_w) nxt = MHalted;
      else if (phase != rot(m_prev) || phase == 5'd0) nxt = MFault;
    end else if (m_mode == MHalted) begin
      if (phase != 5'd0) nxt = MFault;
    end
    if ((m_mode == MIdle || m_mode == MRun) && !m_pending && (hit || halt_req)) begin
      m_pending = 1;
      m_cause   = hit ? 1 : 2;
    end
    if (m_mode == MRun) begin
      m_cyc++;
      if (phase == 5'd16) m_inst++;
    end
    m_last_halt_w = (m_mode == MRun) && hlt_now && (phase == 5'd16);
    m_prev = phase;
    m_mode = nxt;
  endtask

  task automatic check_all();
    bit exp_hlt;
    int exp_cause;
    exp_hlt   = model_hlt();
    exp_cause = (m_mode == MFault) ? 3 : m_cause;
    check_eq("hlt",        32'(hlt),        32'(exp_hlt));
    check_eq("running",    32'(running),    32'(m_mode == MRun));
    check_eq("fault",      32'(fault),      32'(m_mode == MFault));
    check_eq("halt_cause", 32'(halt_cause), 32'(exp_cause));
    check_eq("inst_cnt",   inst_cnt,        clip(m_inst, 32'hFFFF_FFFF));
    check_eq("cyc_cnt",    cyc_cnt,         clip(m_cyc, 32'hFFFF_FFFF));
    check_eq("hlt4",       32'(hlt4),       32'(exp_hlt));
    check_eq("fault4",     32'(fault4),     32'(m_mode == MFault));
    check_eq("running4",   32'(running4),   32'(m_mode == MRun));
    check_eq("cause4",     32'(halt_cause4), 32'(exp_cause));
    check_eq("inst_cnt4",  32'(inst_cnt4),  clip(m_inst, 15));
    check_eq("cyc_cnt4",   32'(cyc_cnt4),   clip(m_cyc, 15));
  endtask

  // Inputs are set at posedge+1; check at +2, then the model absorbs the edge.
  task automatic step();
    #1;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; phase = '0; is_hlt = 1'b0; halt_req = 1'b0;
    #3;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // lead idle cycles, then instructions; hlt_inst (-1 none) decodes HLT in that instruction's X;
  // hr_cycle pulses halt_req; both adds halt_req to the HLT cycle; fault_cyc swaps in a bad phase.
  task automatic run_scn(input int ncyc, input int lead, input int hlt_inst, input int hr_cycle,
                         input bit both, input int fault_cyc, input logic [4:0] fault_ph);
    logic [4:0] gen;
    int         inst_idx;
    bit         hl;
    bit         hit_cyc;
    do_reset();
    gen = '0;
    inst_idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == lead && gen == 5'd0 && m_mode == MIdle) gen = 5'd1;
      phase = gen;
      if (c == fault_cyc) begin
        if (fault_ph != 5'd0) phase = fault_ph;
        else begin
          phase = 5'($urandom_range(1, 31));
          while (phase == gen) phase = 5'($urandom_range(1, 31));
        end
      end
      hit_cyc  = (phase == 5'd4) && (inst_idx == hlt_inst);
      is_hlt   = hit_cyc ? 1'b1 : ((phase != 5'd4) && ($urandom_range(0, 1) == 1));
      halt_req = (c == hr_cycle) || (both && hit_cyc);
      hl = (m_pending && phase[4]) || m_mode == MHalted || m_mode == MFault;
      step();
      if (phase == 5'd16) inst_idx++;
      gen = hl ? 5'd0 : rot(phase);
    end
    is_hlt = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; phase = '0; is_hlt = 1'b0; halt_req = 1'b0;

    // Free run, three full instructions then the next F.
    run_scn(16, 0, -1, -1, 0, -1, 5'd0);
    #1;
    check_eq("t1_inst", inst_cnt, 32'd3);
    check_eq("t1_cyc",  cyc_cnt,  32'd15);
    check_eq("t1_run",  32'(running), 32'd1);

    // HLT in the second instruction, then a long frozen stretch.
    run_scn(35, 0, 1, -1, 0, -1, 5'd0);
    #1;
    check_eq("t2_cause", 32'(halt_cause), 32'd1);
    check_eq("t2_inst",  inst_cnt, 32'd2);
    check_eq("t2_run",   32'(running), 32'd0);
    check_eq("t2_hlt",   32'(hlt), 32'd1);

    // halt_req during R of the first instruction.
    run_scn(12, 0, -1, 1, 0, -1, 5'd0);
    #1;
    check_eq("t3_cause", 32'(halt_cause), 32'd2);
    check_eq("t3_inst",  inst_cnt, 32'd1);

    // HLT and halt_req together.
    run_scn(12, 0, 0, -1, 1, -1, 5'd0);
    #1;
    check_eq("t4_cause", 32'(halt_cause), 32'd1);
    check_eq("t4_inst",  inst_cnt, 32'd1);

    // Phase jump R -> M.
    run_scn(10, 0, -1, -1, 0, 2, 5'b01000);
    #1;
    check_eq("t5_fault", 32'(fault), 32'd1);
    check_eq("t5_cause", 32'(halt_cause), 32'd3);
    check_eq("t5_hlt",   32'(hlt), 32'd1);
    check_eq("t5_cyc",   cyc_cnt, 32'd2);
    do_reset();

    // halt_req while still idle: first instruction completes.
    run_scn(15, 3, -1, 1, 0, -1, 5'd0);
    #1;
    check_eq("idle_req_inst", inst_cnt, 32'd1);

    // Twenty instructions: 4-bit counters saturate.
    run_scn(101, 0, -1, -1, 0, -1, 5'd0);
    #1;
    check_eq("t6_inst4", 32'(inst_cnt4), 32'd15);
    check_eq("t6_cyc4",  32'(cyc_cnt4),  32'd15);
    check_eq("t6_inst",  inst_cnt, 32'd20);

    for (int k = 0; k < 40; k++) begin
      int hi, hr, fc;
      hi = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 4));
      hr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      fc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_scn(int'($urandom_range(5, 60)), int'($urandom_range(0, 3)), hi, hr,
              1'($urandom_range(0, 1)), fc, 5'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
